// File: rtl/axil_reg_rd_bridge.sv
// AXI-lite read slave that turns each AR beat into a held register-read strobe and returns one R beat.
// Optional: define AXIL_REG_RD_BRIDGE_SECURE_EN to answer non-secure reads (arprot[1]=1) with SLVERR.
module axil_reg_rd_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  localparam int ALIGN_BITS = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t                r_state;
  logic                  r_arready;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rvalid;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_en;
  logic [CNT_W-1:0]      r_cnt;

  logic w_ar_fire;
  logic w_timed_out;
  logic w_reject;
  logic w_unused;

  assign w_ar_fire   = s_axil_arvalid && r_arready;
  assign w_timed_out = TIMEOUT_EN && (r_cnt == '0);
  assign w_unused    = ^s_axil_arprot;

`ifdef AXIL_REG_RD_BRIDGE_SECURE_EN
  assign w_reject = s_axil_arprot[1];
`else
  assign w_reject = 1'b0;
`endif

  // Wait freezes the timeout budget; an ack qualified by !wait always beats the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_arready <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_fire) begin
            r_arready <= 1'b0;
            if (w_reject) begin
              r_rdata  <= '0;
              r_rresp  <= 2'b10;
              r_rvalid <= 1'b1;
              r_state  <= RESP;
            end else begin
              r_rd_addr <= s_axil_araddr & ADDR_MASK;
              r_rd_en   <= 1'b1;
              r_cnt     <= CNT_INIT;
              r_state   <= READ;
            end
          end
        end
        READ: begin
          if (reg_rd_ack && !reg_rd_wait) begin
            r_rdata  <= reg_rd_data;
            r_rresp  <= 2'b00;
            r_rvalid <= 1'b1;
            r_rd_en  <= 1'b0;
            r_state  <= RESP;
          end else if (!reg_rd_wait) begin
            if (w_timed_out) begin
              r_rdata  <= '0;
              r_rresp  <= 2'b10;
              r_rvalid <= 1'b1;
              r_rd_en  <= 1'b0;
              r_state  <= RESP;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        RESP: begin
          if (s_axil_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axil_arready = r_arready;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rvalid  = r_rvalid;
  assign reg_rd_addr    = r_rd_addr;
  assign reg_rd_en      = r_rd_en;

endmodule

// File: tb/tb_axil_reg_rd_bridge.sv
// Scoreboard bench for axil_reg_rd_bridge: stimulus pushes expected R beats, a monitor pops and compares.
// Secure-read checks follow AXIL_REG_RD_BRIDGE_SECURE_EN when it is defined.
module tb_axil_reg_rd_bridge;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] arAddr = '0;
  logic [2:0]  arProt = '0;
  logic        arValid = 1'b0;
  logic        arReady;
  logic [31:0] rData;
  logic [1:0]  rResp;
  logic        rValid;
  logic        rReady = 1'b1;
  logic [31:0] regRdAddr;
  logic        regRdEn;
  logic [31:0] regRdData = '0;
  logic        regRdWait = 1'b0;
  logic        regRdAck = 1'b0;

  int          compareCount = 0;
  int          mismatchCount = 0;
  exp_t        sbQueue[$];
  exp_t        expItem;

  int          decWait = 0;
  bit          decAckOn = 1'b1;
  logic [31:0] decData = '0;
  int          decCnt = 0;
  int          enCycles;

  axil_reg_rd_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axil_araddr(arAddr),
    .s_axil_arprot(arProt),
    .s_axil_arvalid(arValid),
    .s_axil_arready(arReady),
    .s_axil_rdata(rData),
    .s_axil_rresp(rResp),
    .s_axil_rvalid(rValid),
    .s_axil_rready(rReady),
    .reg_rd_addr(regRdAddr),
    .reg_rd_en(regRdEn),
    .reg_rd_data(regRdData),
    .reg_rd_wait(regRdWait),
    .reg_rd_ack(regRdAck)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Decoder model: holds wait for decWait strobe cycles, then acks with decData if enabled.
  always @(posedge clk) begin
    #1;
    if (regRdEn) begin
      regRdWait = (decCnt < decWait);
      regRdAck  = decAckOn && (decCnt >= decWait);
      regRdData = (decAckOn && (decCnt >= decWait)) ? decData : 32'hBAD0BAD0;
      decCnt++;
    end else begin
      regRdWait = 1'b0;
      regRdAck  = 1'b0;
      decCnt    = 0;
    end
  end

  // Monitor: every R handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && rValid && rReady) begin
      if (sbQueue.size() == 0) begin
        compareCount++;
        mismatchCount++;
        $display("[TB] FAIL unexpectedBeat: got rdata=0x%0h rresp=%0d, required no beat", rData, rResp);
      end else begin
        expItem = sbQueue.pop_front();
        checkOutput("rdata", rData, expItem.data);
        checkOutput("rresp", rResp, expItem.resp);
      end
    end
  end

  // Issues one AR beat (returns just after the handshake edge) and records the expected R beat.
  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] prot,
                               input logic [31:0] expData, input logic [1:0] expResp,
                               input bit expectBeat);
    exp_t e;
    bit accepted;
    e.data = expData;
    e.resp = expResp;
    if (expectBeat) sbQueue.push_back(e);
    arAddr  = addr;
    arProt  = prot;
    arValid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (arReady) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    arValid = 1'b0;
    if (!accepted) begin
      compareCount++;
      mismatchCount++;
      $display("[TB] FAIL arHandshake: got arready=0 for 50 cycles, required 1");
    end
  endtask

  task automatic measureEn(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100 && regRdEn; i++) begin
      cnt++;
      stepCycles(1);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 60 && sbQueue.size() != 0; i++) stepCycles(1);
    stepCycles(1);
    checkOutput("drain", 64'(sbQueue.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500us, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stepCycles(2);
    checkOutput("rstArready", arReady, 0);
    checkOutput("rstRvalid", rValid, 0);
    checkOutput("rstRresp", rResp, 0);
    checkOutput("rstRdata", rData, 0);
    checkOutput("rstEn", regRdEn, 0);
    checkOutput("rstAddr", regRdAddr, 0);
    rst = 1'b0;
    checkOutput("arreadyAtRelease", arReady, 0);
    stepCycles(1);
    checkOutput("arreadyAfterRelease", arReady, 1);

    // Basic read with immediate ack and unaligned address.
    decData = 32'hDEADBEEF;
    applyStimulus(32'h0000_1237, 3'b000, 32'hDEADBEEF, 2'b00, 1'b1);
    checkOutput("basicAddr", regRdAddr, 32'h0000_1234);
    checkOutput("basicEn", regRdEn, 1);
    checkOutput("basicRvalidEarly", rValid, 0);
    stepCycles(1);
    checkOutput("basicRvalid", rValid, 1);
    checkOutput("basicEnDrop", regRdEn, 0);
    waitDrain();

    // Ten wait cycles then ack: no timeout, strobe high for 11 cycles.
    decWait = 10;
    decData = 32'h5A5A5A5A;
    applyStimulus(32'h0000_0010, 3'b000, 32'h5A5A5A5A, 2'b00, 1'b1);
    measureEn(enCycles);
    checkOutput("waitEnCycles", 64'(enCycles), 64'd11);
    waitDrain();
    decWait = 0;

    // Dead decoder: timeout after exactly 4 strobe cycles, then a normal read recovers.
    decAckOn = 1'b0;
    applyStimulus(32'h0000_0300, 3'b000, 32'h0, 2'b10, 1'b1);
    measureEn(enCycles);
    checkOutput("timeoutEnCycles", 64'(enCycles), 64'd4);
    waitDrain();
    decAckOn = 1'b1;
    decData = 32'h11223344;
    applyStimulus(32'h0000_0306, 3'b000, 32'h11223344, 2'b00, 1'b1);
    checkOutput("recoverAddr", regRdAddr, 32'h0000_0304);
    waitDrain();

    // Backpressure: R held stable, second AR waits until after the R handshake.
    rReady = 1'b0;
    decData = 32'hCAFEF00D;
    applyStimulus(32'h0000_0100, 3'b000, 32'hCAFEF00D, 2'b00, 1'b1);
    stepCycles(1);
    decData = 32'h0BADCAFE;
    sbQueue.push_back('{32'h0BADCAFE, 2'b00});
    arAddr  = 32'h0000_0200;
    arValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpRvalid", rValid, 1);
      checkOutput("bpRdata", rData, 32'hCAFEF00D);
      checkOutput("bpRresp", rResp, 0);
      checkOutput("bpArready", arReady, 0);
      stepCycles(1);
    end
    rReady = 1'b1;
    stepCycles(1);
    checkOutput("bpRvalidDone", rValid, 0);
    checkOutput("bpArreadyBack", arReady, 1);
    stepCycles(1);
    checkOutput("bpSecondAccepted", arReady, 0);
    checkOutput("bpSecondEn", regRdEn, 1);
    checkOutput("bpSecondAddr", regRdAddr, 32'h0000_0200);
    arValid = 1'b0;
    waitDrain();

    // Reset during READ drops the access with no R beat.
    decAckOn = 1'b0;
    applyStimulus(32'h0000_0400, 3'b000, 32'h0, 2'b00, 1'b0);
    checkOutput("midEn", regRdEn, 1);
    stepCycles(1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstEn", regRdEn, 0);
    checkOutput("midRstRvalid", rValid, 0);
    checkOutput("midRstArready", arReady, 0);
    checkOutput("midRstAddr", regRdAddr, 0);
    stepCycles(1);
    rst = 1'b0;
    checkOutput("midReleaseArready", arReady, 0);
    stepCycles(1);
    checkOutput("midArreadyBack", arReady, 1);
    decAckOn = 1'b1;
    stepCycles(5);
    checkOutput("midNoBeatRvalid", rValid, 0);

`ifdef AXIL_REG_RD_BRIDGE_SECURE_EN
    // Non-secure read is rejected without touching the decoder.
    applyStimulus(32'h0000_0500, 3'b010, 32'h0, 2'b10, 1'b1);
    checkOutput("secEn", regRdEn, 0);
    checkOutput("secRvalid", rValid, 1);
    waitDrain();
    decData = 32'h600DF00D;
    applyStimulus(32'h0000_0504, 3'b000, 32'h600DF00D, 2'b00, 1'b1);
    checkOutput("secOkEn", regRdEn, 1);
    waitDrain();
`else
    // Without the secure option arprot has no effect.
    decData = 32'h600DF00D;
    applyStimulus(32'h0000_0500, 3'b010, 32'h600DF00D, 2'b00, 1'b1);
    checkOutput("protIgnoredEn", regRdEn, 1);
    waitDrain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
